// File: rtl/ysyx_23060236_dcache_ctrl_if.sv
// Bundle of LSU request/response, cache-array and single-beat memory
// signals seen by the data-cache controller.
interface ysyx_23060236_dcache_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_wen;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_wmask;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic [31:0] c_araddr;
   logic [31:0] c_rdata;
   logic        c_hit;
   logic [31:0] c_awaddr;
   logic [31:0] c_wdata;
   logic        c_wvalid;
   logic        c_dirty;
   logic        c_wdt;
   logic [25:0] c_reptag;
   logic [31:0] c_repdata;
   logic        mem_arvalid;
   logic        mem_arready;
   logic [31:0] mem_araddr;
   logic        mem_rvalid;
   logic        mem_rready;
   logic [31:0] mem_rdata;
   logic        mem_awvalid;
   logic        mem_awready;
   logic [31:0] mem_awaddr;
   logic        mem_wvalid;
   logic        mem_wready;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_bvalid;
   logic        mem_bready;

   modport master (
      input  req_valid, req_wen, req_addr, req_wdata, req_wmask,
      output req_ready,
      output resp_valid, resp_rdata,
      input  resp_ready,
      output c_araddr, c_awaddr, c_wdata, c_wvalid, c_dirty,
      input  c_rdata, c_hit, c_wdt, c_reptag, c_repdata,
      output mem_arvalid, mem_araddr, mem_rready,
      input  mem_arready, mem_rvalid, mem_rdata,
      output mem_awvalid, mem_awaddr, mem_wvalid, mem_wdata,
      output mem_wstrb, mem_bready,
      input  mem_awready, mem_wready, mem_bvalid
   );

   modport slave (
      output req_valid, req_wen, req_addr, req_wdata, req_wmask,
      input  req_ready,
      input  resp_valid, resp_rdata,
      output resp_ready,
      input  c_araddr, c_awaddr, c_wdata, c_wvalid, c_dirty,
      output c_rdata, c_hit, c_wdt, c_reptag, c_repdata,
      input  mem_arvalid, mem_araddr, mem_rready,
      output mem_arready, mem_rvalid, mem_rdata,
      input  mem_awvalid, mem_awaddr, mem_wvalid, mem_wdata,
      input  mem_wstrb, mem_bready,
      output mem_awready, mem_wready, mem_bvalid
   );
endinterface

// File: rtl/ysyx_23060236_dcache_ctrl.sv
// Controller for a 16-line direct-mapped write-back data cache:
// lookup, write-allocate refill, dirty write-back and uncached bypass.
module ysyx_23060236_dcache_ctrl #(
   parameter logic [31:0] CACHE_BASE = 32'h8000_0000,
   parameter logic [31:0] CACHE_SIZE = 32'h0800_0000
) (
   input logic clock,
   input logic reset,
   ysyx_23060236_dcache_ctrl_if.master bus
);

   typedef enum logic [3:0] {
      IDLE, LOOKUP, MRD_AR, MRD_R, FILL,
      WB_AW, WB_B, UNC_AW, UNC_B, RESP
   } state_e;

   state_e      state_q, state_d;
   logic        wen_q, wen_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wmask_q, wmask_d;
   logic [31:0] rdata_q, rdata_d;
   logic        cach_q, cach_d;
   logic        aw_done_q, aw_done_d;
   logic        w_done_q, w_done_d;

   logic [32:0] win_lo, win_hi, req_ext;
   logic        req_cach;
   logic        aw_ok, w_ok;

   function automatic logic [31:0] merge(
      input logic [31:0] old,
      input logic [31:0] wd,
      input logic [3:0]  m
   );
      logic [31:0] r;
      for (int i = 0; i < 4; i++)
         r[8*i +: 8] = m[i] ? wd[8*i +: 8] : old[8*i +: 8];
      return r;
   endfunction

   // Cacheable window check, 33-bit so base+size cannot wrap
   always_comb begin
      win_lo   = {1'b0, CACHE_BASE};
      win_hi   = {1'b0, CACHE_BASE} + {1'b0, CACHE_SIZE};
      req_ext  = {1'b0, bus.req_addr};
      req_cach = (req_ext >= win_lo) && (req_ext < win_hi);
   end

   // State and request registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         wen_q     <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wmask_q   <= '0;
         rdata_q   <= '0;
         cach_q    <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         wen_q     <= wen_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wmask_q   <= wmask_d;
         rdata_q   <= rdata_d;
         cach_q    <= cach_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end

   // Next-state and output decode
   always_comb begin
      state_d   = state_q;
      wen_d     = wen_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wmask_d   = wmask_q;
      rdata_d   = rdata_q;
      cach_d    = cach_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;

      bus.req_ready   = 1'b0;
      bus.resp_valid  = 1'b0;
      bus.resp_rdata  = rdata_q;
      bus.c_araddr    = addr_q;
      bus.c_awaddr    = addr_q;
      bus.c_wdata     = rdata_q;
      bus.c_wvalid    = 1'b0;
      bus.c_dirty     = 1'b0;
      bus.mem_arvalid = 1'b0;
      bus.mem_araddr  = addr_q;
      bus.mem_rready  = 1'b0;
      bus.mem_awvalid = 1'b0;
      bus.mem_awaddr  = addr_q;
      bus.mem_wvalid  = 1'b0;
      bus.mem_wdata   = wdata_q;
      bus.mem_wstrb   = wmask_q;
      bus.mem_bready  = 1'b0;

      // AW and W retire independently; a channel is "ok" once its
      // handshake has happened now or in an earlier cycle.
      aw_ok = aw_done_q | bus.mem_awready;
      w_ok  = w_done_q | bus.mem_wready;

      unique case (state_q)
         IDLE: begin
            bus.req_ready = 1'b1;
            aw_done_d     = 1'b0;
            w_done_d      = 1'b0;
            if (bus.req_valid) begin
               wen_d   = bus.req_wen;
               addr_d  = bus.req_addr;
               wdata_d = bus.req_wdata;
               wmask_d = bus.req_wmask;
               cach_d  = req_cach;
               if (req_cach)
                  state_d = LOOKUP;
               else if (bus.req_wen)
                  state_d = UNC_AW;
               else
                  state_d = MRD_AR;
            end
         end
         LOOKUP: begin
            if (bus.c_hit) begin
               if (wen_q) begin
                  bus.c_wvalid = 1'b1;
                  bus.c_wdata  = merge(bus.c_rdata, wdata_q, wmask_q);
                  bus.c_dirty  = 1'b1;
               end else begin
                  rdata_d = bus.c_rdata;
               end
               state_d = RESP;
            end else begin
               state_d = MRD_AR;
            end
         end
         MRD_AR: begin
            bus.mem_arvalid = 1'b1;
            if (bus.mem_arready)
               state_d = MRD_R;
         end
         MRD_R: begin
            bus.mem_rready = 1'b1;
            if (bus.mem_rvalid) begin
               rdata_d = bus.mem_rdata;
               state_d = cach_q ? FILL : RESP;
            end
         end
         FILL: begin
            bus.c_wvalid = 1'b1;
            bus.c_wdata  = wen_q ? merge(rdata_q, wdata_q, wmask_q)
                                 : rdata_q;
            bus.c_dirty  = wen_q;
            // c_wdt still reflects the pre-write victim this cycle
            state_d = bus.c_wdt ? WB_AW : RESP;
         end
         WB_AW, UNC_AW: begin
            bus.mem_awvalid = ~aw_done_q;
            bus.mem_wvalid  = ~w_done_q;
            if (state_q == WB_AW) begin
               bus.mem_awaddr = {bus.c_reptag, addr_q[5:2], 2'b00};
               bus.mem_wdata  = bus.c_repdata;
               bus.mem_wstrb  = 4'hF;
            end
            aw_done_d = aw_ok;
            w_done_d  = w_ok;
            if (aw_ok && w_ok) begin
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = (state_q == WB_AW) ? WB_B : UNC_B;
            end
         end
         WB_B, UNC_B: begin
            bus.mem_bready = 1'b1;
            if (bus.mem_bvalid)
               state_d = RESP;
         end
         RESP: begin
            bus.resp_valid = 1'b1;
            if (bus.resp_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_ysyx_23060236_dcache_ctrl.sv
// Directed bench for the data-cache controller with a behavioural
// cache array and single-beat memory slave.
module tb_ysyx_23060236_dcache_ctrl;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   ysyx_23060236_dcache_ctrl_if bus ();

   ysyx_23060236_dcache_ctrl dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // ---------------- cache array model ----------------
   logic [25:0] tag_a  [16];
   logic [31:0] data_a [16];
   logic        v_a    [16];
   logic        d_a    [16];
   logic        arr_clr;
   logic [25:0] reptag_q;
   logic [31:0] repdata_q;
   int          cw_cnt = 0;

   assign bus.c_hit = v_a[bus.c_araddr[5:2]] &&
                      (tag_a[bus.c_araddr[5:2]] == bus.c_araddr[31:6]);
   assign bus.c_rdata = data_a[bus.c_araddr[5:2]];
   assign bus.c_wdt = v_a[bus.c_awaddr[5:2]] && d_a[bus.c_awaddr[5:2]] &&
                      (tag_a[bus.c_awaddr[5:2]] != bus.c_awaddr[31:6]);
   assign bus.c_reptag  = reptag_q;
   assign bus.c_repdata = repdata_q;

   always @(posedge clock) begin
      if (arr_clr) begin
         for (int i = 0; i < 16; i++) begin
            v_a[i]    <= 1'b0;
            d_a[i]    <= 1'b0;
            tag_a[i]  <= '0;
            data_a[i] <= '0;
         end
         reptag_q  <= '0;
         repdata_q <= '0;
      end else if (bus.c_wvalid) begin
         reptag_q  <= tag_a[bus.c_awaddr[5:2]];
         repdata_q <= data_a[bus.c_awaddr[5:2]];
         v_a[bus.c_awaddr[5:2]]    <= 1'b1;
         d_a[bus.c_awaddr[5:2]]    <= bus.c_dirty;
         tag_a[bus.c_awaddr[5:2]]  <= bus.c_awaddr[31:6];
         data_a[bus.c_awaddr[5:2]] <= bus.c_wdata;
         cw_cnt <= cw_cnt + 1;
      end
   end

   // ---------------- memory slave model ----------------
   logic        rvalid_q;
   logic        r_hold;
   logic [31:0] mem_rval;
   int          ar_cnt = 0;
   logic [31:0] ar_last;
   int          aw_delay;
   int          aw_wait;
   logic        aw_got, w_got, bvalid_q;
   int          aw_cnt = 0, w_cnt = 0, b_cnt = 0;
   int          awv_cyc = 0, wv_cyc = 0;
   logic [31:0] aw_last, w_last;
   logic [3:0]  s_last;

   assign bus.mem_arready = 1'b1;
   assign bus.mem_rvalid  = rvalid_q & ~r_hold;
   assign bus.mem_rdata   = mem_rval;
   assign bus.mem_awready = bus.mem_awvalid && (aw_wait >= aw_delay);
   assign bus.mem_wready  = 1'b1;
   assign bus.mem_bvalid  = bvalid_q;

   always @(posedge clock) begin
      if (reset) begin
         rvalid_q <= 1'b0;
      end else if (bus.mem_arvalid && bus.mem_arready) begin
         rvalid_q <= 1'b1;
         ar_cnt   <= ar_cnt + 1;
         ar_last  <= bus.mem_araddr;
      end else if (bus.mem_rvalid && bus.mem_rready) begin
         rvalid_q <= 1'b0;
      end
   end

   always @(posedge clock) begin
      if (bus.mem_awvalid) awv_cyc <= awv_cyc + 1;
      if (bus.mem_wvalid)  wv_cyc  <= wv_cyc + 1;
      if (reset) begin
         aw_wait  <= 0;
         aw_got   <= 1'b0;
         w_got    <= 1'b0;
         bvalid_q <= 1'b0;
      end else begin
         if (bus.mem_awvalid && bus.mem_awready) begin
            aw_got  <= 1'b1;
            aw_wait <= 0;
            aw_cnt  <= aw_cnt + 1;
            aw_last <= bus.mem_awaddr;
         end else if (bus.mem_awvalid) begin
            aw_wait <= aw_wait + 1;
         end
         if (bus.mem_wvalid && bus.mem_wready) begin
            w_got  <= 1'b1;
            w_cnt  <= w_cnt + 1;
            w_last <= bus.mem_wdata;
            s_last <= bus.mem_wstrb;
         end
         if (bvalid_q && bus.mem_bready) begin
            bvalid_q <= 1'b0;
            b_cnt    <= b_cnt + 1;
         end else if (!bvalid_q &&
                      (aw_got || (bus.mem_awvalid && bus.mem_awready)) &&
                      (w_got || (bus.mem_wvalid && bus.mem_wready))) begin
            bvalid_q <= 1'b1;
            aw_got   <= 1'b0;
            w_got    <= 1'b0;
         end
      end
   end

   // ---------------- request driver ----------------
   task automatic do_req(
      input  logic        wen,
      input  logic [31:0] addr,
      input  logic [31:0] wdata,
      input  logic [3:0]  wmask,
      input  int          hold,
      output int          lat,
      output logic [31:0] rd,
      output bit          stable
   );
      @(negedge clock);
      bus.req_valid  = 1'b1;
      bus.req_wen    = wen;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      bus.req_wmask  = wmask;
      bus.resp_ready = 1'b0;
      @(posedge clock);
      #1;
      bus.req_valid = 1'b0;
      lat = 1;
      while (!bus.resp_valid && lat < 60) begin
         @(posedge clock);
         #1;
         lat++;
      end
      rd = bus.resp_rdata;
      stable = 1'b1;
      repeat (hold) begin
         @(posedge clock);
         #1;
         if (!bus.resp_valid || bus.resp_rdata !== rd) stable = 1'b0;
      end
      bus.resp_ready = 1'b1;
      @(posedge clock);
      #1;
      bus.resp_ready = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      n_cmp++;
      if (bus.req_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_req_ready: got %b want 1", bus.req_ready);
      end
      n_cmp++;
      if ({bus.resp_valid, bus.c_wvalid, bus.mem_arvalid, bus.mem_rready,
           bus.mem_awvalid, bus.mem_wvalid, bus.mem_bready} !== 7'b0) begin
         n_bad++;
         $display("FAIL reset_valids: got %b want 0000000",
                  {bus.resp_valid, bus.c_wvalid, bus.mem_arvalid,
                   bus.mem_rready, bus.mem_awvalid, bus.mem_wvalid,
                   bus.mem_bready});
      end
   endtask

   task automatic test_cold_miss();
      int lat; logic [31:0] rd; bit st; int ar0, aw0;
      ar0 = ar_cnt; aw0 = aw_cnt;
      mem_rval = 32'h1234_5678;
      do_req(1'b0, 32'h8000_0010, 32'h0, 4'h0, 0, lat, rd, st);
      n_cmp++;
      if (lat !== 5) begin
         n_bad++; $display("FAIL cold_lat: got %0d want 5", lat);
      end
      n_cmp++;
      if (rd !== 32'h1234_5678) begin
         n_bad++; $display("FAIL cold_rdata: got %h want 12345678", rd);
      end
      n_cmp++;
      if (ar_cnt - ar0 !== 1 || ar_last !== 32'h8000_0010) begin
         n_bad++;
         $display("FAIL cold_ar: got n=%0d addr=%h want n=1 addr=80000010",
                  ar_cnt - ar0, ar_last);
      end
      n_cmp++;
      if (data_a[4] !== 32'h1234_5678 || d_a[4] !== 1'b0) begin
         n_bad++;
         $display("FAIL cold_array: got %h/%b want 12345678/0",
                  data_a[4], d_a[4]);
      end
      n_cmp++;
      if (aw_cnt !== aw0) begin
         n_bad++; $display("FAIL cold_no_aw: got %0d want 0", aw_cnt - aw0);
      end
   endtask

   task automatic test_hit_load();
      int lat; logic [31:0] rd; bit st; int ar0;
      ar0 = ar_cnt;
      do_req(1'b0, 32'h8000_0010, 32'h0, 4'h0, 0, lat, rd, st);
      n_cmp++;
      if (lat !== 2) begin
         n_bad++; $display("FAIL hit_lat: got %0d want 2", lat);
      end
      n_cmp++;
      if (rd !== 32'h1234_5678) begin
         n_bad++; $display("FAIL hit_rdata: got %h want 12345678", rd);
      end
      n_cmp++;
      if (ar_cnt !== ar0) begin
         n_bad++; $display("FAIL hit_no_ar: got %0d want 0", ar_cnt - ar0);
      end
   endtask

   task automatic test_store_hit();
      int lat; logic [31:0] rd; bit st; int ar0, aw0, cw0;
      ar0 = ar_cnt; aw0 = aw_cnt; cw0 = cw_cnt;
      do_req(1'b1, 32'h8000_0010, 32'hAABB_CCDD, 4'b0011, 0, lat, rd, st);
      n_cmp++;
      if (lat !== 2) begin
         n_bad++; $display("FAIL store_lat: got %0d want 2", lat);
      end
      n_cmp++;
      if (data_a[4] !== 32'h1234_CCDD || d_a[4] !== 1'b1) begin
         n_bad++;
         $display("FAIL store_array: got %h/%b want 1234ccdd/1",
                  data_a[4], d_a[4]);
      end
      n_cmp++;
      if (ar_cnt !== ar0 || aw_cnt !== aw0 || cw_cnt - cw0 !== 1) begin
         n_bad++;
         $display("FAIL store_traffic: got ar=%0d aw=%0d cw=%0d want 0 0 1",
                  ar_cnt - ar0, aw_cnt - aw0, cw_cnt - cw0);
      end
   endtask

   task automatic test_dirty_miss();
      int lat; logic [31:0] rd; bit st; int b0;
      b0 = b_cnt;
      mem_rval = 32'hCAFE_F00D;
      do_req(1'b0, 32'h8000_0050, 32'h0, 4'h0, 0, lat, rd, st);
      n_cmp++;
      if (ar_last !== 32'h8000_0050) begin
         n_bad++; $display("FAIL dm_ar: got %h want 80000050", ar_last);
      end
      n_cmp++;
      if (aw_last !== 32'h8000_0010 || w_last !== 32'h1234_CCDD ||
          s_last !== 4'hF) begin
         n_bad++;
         $display("FAIL dm_wb: got %h %h %h want 80000010 1234ccdd f",
                  aw_last, w_last, s_last);
      end
      n_cmp++;
      if (b_cnt - b0 !== 1 || lat !== 7) begin
         n_bad++;
         $display("FAIL dm_b_lat: got b=%0d lat=%0d want 1 7",
                  b_cnt - b0, lat);
      end
      n_cmp++;
      if (rd !== 32'hCAFE_F00D) begin
         n_bad++; $display("FAIL dm_rdata: got %h want cafef00d", rd);
      end
      n_cmp++;
      if (tag_a[4] !== 26'h200_0001 || d_a[4] !== 1'b0) begin
         n_bad++;
         $display("FAIL dm_array: got %h/%b want 2000001/0",
                  tag_a[4], d_a[4]);
      end
   endtask

   task automatic test_uncached();
      int lat; logic [31:0] rd; bit st; int cw0;
      cw0 = cw_cnt;
      do_req(1'b1, 32'hA000_0000, 32'h1122_3344, 4'b1000, 0, lat, rd, st);
      n_cmp++;
      if (aw_last !== 32'hA000_0000 || w_last !== 32'h1122_3344 ||
          s_last !== 4'h8 || lat !== 3) begin
         n_bad++;
         $display("FAIL unc_st: got %h %h %h lat=%0d want a0000000 11223344 8 3",
                  aw_last, w_last, s_last, lat);
      end
      mem_rval = 32'h5566_7788;
      do_req(1'b0, 32'h1000_0004, 32'h0, 4'h0, 0, lat, rd, st);
      n_cmp++;
      if (rd !== 32'h5566_7788 || ar_last !== 32'h1000_0004 || lat !== 3) begin
         n_bad++;
         $display("FAIL unc_ld: got %h %h lat=%0d want 55667788 10000004 3",
                  rd, ar_last, lat);
      end
      n_cmp++;
      if (cw_cnt !== cw0) begin
         n_bad++; $display("FAIL unc_no_cw: got %0d want 0", cw_cnt - cw0);
      end
   endtask

   task automatic test_window();
      logic [31:0] addrs [4];
      int          lats  [4];
      int lat; logic [31:0] rd; bit st;
      addrs[0] = 32'h87FF_FFFC; lats[0] = 5;
      addrs[1] = 32'h8800_0000; lats[1] = 3;
      addrs[2] = 32'h7FFF_FFFC; lats[2] = 3;
      addrs[3] = 32'hFFFF_FFFC; lats[3] = 3;
      mem_rval = 32'h0BAD_CAFE;
      for (int i = 0; i < 4; i++) begin
         do_req(1'b0, addrs[i], 32'h0, 4'h0, 0, lat, rd, st);
         n_cmp++;
         if (lat !== lats[i] || rd !== 32'h0BAD_CAFE) begin
            n_bad++;
            $display("FAIL window_%h: got lat=%0d rd=%h want %0d 0badcafe",
                     addrs[i], lat, rd, lats[i]);
         end
      end
   endtask

   task automatic test_aw_delay();
      int lat; logic [31:0] rd; bit st; int av0, wv0, b0;
      av0 = awv_cyc; wv0 = wv_cyc; b0 = b_cnt;
      aw_delay = 3;
      do_req(1'b1, 32'h2000_0008, 32'hDEAD_BEEF, 4'hF, 0, lat, rd, st);
      aw_delay = 0;
      n_cmp++;
      if (wv_cyc - wv0 !== 1 || awv_cyc - av0 !== 4) begin
         n_bad++;
         $display("FAIL awdly_valid: got w=%0d aw=%0d want 1 4",
                  wv_cyc - wv0, awv_cyc - av0);
      end
      n_cmp++;
      if (b_cnt - b0 !== 1 || lat !== 6) begin
         n_bad++;
         $display("FAIL awdly_b: got b=%0d lat=%0d want 1 6",
                  b_cnt - b0, lat);
      end
      do_req(1'b0, 32'h8000_0050, 32'h0, 4'h0, 4, lat, rd, st);
      n_cmp++;
      if (st !== 1'b1 || rd !== 32'hCAFE_F00D) begin
         n_bad++;
         $display("FAIL resp_hold: got stable=%b rd=%h want 1 cafef00d",
                  st, rd);
      end
   endtask

   task automatic test_reset_mid();
      int lat; logic [31:0] rd; bit st; int n; int aw0;
      r_hold = 1'b1;
      @(negedge clock);
      bus.req_valid = 1'b1;
      bus.req_wen   = 1'b0;
      bus.req_addr  = 32'h1000_0000;
      @(posedge clock);
      #1;
      bus.req_valid = 1'b0;
      n = 0;
      while (!bus.mem_rready && n < 20) begin
         @(posedge clock);
         #1;
         n++;
      end
      n_cmp++;
      if (bus.mem_rready !== 1'b1) begin
         n_bad++; $display("FAIL rst_reach_r: got %b want 1", bus.mem_rready);
      end
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      test_reset();
      reset  = 1'b0;
      r_hold = 1'b0;
      do_req(1'b0, 32'h8000_0050, 32'h0, 4'h0, 0, lat, rd, st);
      n_cmp++;
      if (lat !== 2 || rd !== 32'hCAFE_F00D) begin
         n_bad++;
         $display("FAIL rst_hit: got lat=%0d rd=%h want 2 cafef00d", lat, rd);
      end
      aw0 = aw_cnt;
      mem_rval = 32'h7777_0001;
      do_req(1'b0, 32'h8000_0090, 32'h0, 4'h0, 0, lat, rd, st);
      n_cmp++;
      if (lat !== 5 || rd !== 32'h7777_0001 || aw_cnt !== aw0) begin
         n_bad++;
         $display("FAIL rst_miss: got lat=%0d rd=%h aw=%0d want 5 77770001 0",
                  lat, rd, aw_cnt - aw0);
      end
   endtask

   initial begin
      reset          = 1'b1;
      arr_clr        = 1'b1;
      r_hold         = 1'b0;
      aw_delay       = 0;
      mem_rval       = '0;
      bus.req_valid  = 1'b0;
      bus.req_wen    = 1'b0;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      bus.req_wmask  = '0;
      bus.resp_ready = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      test_reset();
      @(negedge clock);
      reset   = 1'b0;
      arr_clr = 1'b0;
      @(posedge clock);
      #1;
      test_reset();
      test_cold_miss();
      test_hit_load();
      test_store_hit();
      test_dirty_miss();
      test_uncached();
      test_window();
      test_aw_delay();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
